t_edge_counter: RTL and testbench

- Counts rising edges of a slow, possibly asynchronous event input `d`. This is the same toggle-style stimulus a T flip-flop stage receives.
- Produces a modulo up/down count, built from a bank of T-type toggle cells with the toggle enables computed synchronously.
- Sits directly downstream of the flip-flop stage: it consumes the `q` or `d` style single-bit toggle stream and turns it into a multi-bit count plus a terminal-count pulse for later stages.

---
 rtl/flipflop_pkg.sv | 13 +
 rtl/t_ff_cell.sv | 35 +++
 rtl/t_edge_counter.sv | 113 +++++++++++
 tb/tb_t_edge_counter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flipflop_pkg.sv
// Shared definitions for the flip-flop / edge-counter family: synchronizer
// depth and the load-value clamp used by the counter and its reference model.
package flipflop_pkg;

    localparam int SYNC_STAGES = 2;

    // Limit a value to the legal count range 0..modulus-1.
    function automatic int unsigned clamp_mod(input int unsigned val,
                                              input int unsigned modulus);
        return (val >= modulus) ? (modulus - 1) : val;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T-type toggle cell with a direct load path. Load wins over toggle.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic ld_val,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next state: load, else toggle when t is set, else hold.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_val;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    // State flop, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/t_edge_counter.sv
// Modulo up/down counter of rising edges on an asynchronous event input.
// d is synchronized, edge-detected, and each accepted edge steps a bank of
// T cells; wrap boundaries and loads go through the cells' load path.
module t_edge_counter
    import flipflop_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             edge_seen
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   d_prev_q;
    logic                   d_prev_d;
    logic                   edge_seen_q;
    logic                   edge_seen_d;
    logic                   tc_q;
    logic                   tc_d;

    logic                   d_s;
    logic                   rise;
    logic                   step;
    logic [WIDTH-1:0]       q_cnt;
    logic [WIDTH-1:0]       load_clamped;
    logic [WIDTH-1:0]       t_vec;
    logic [WIDTH-1:0]       cell_ld_val;
    logic                   cell_ld;
    logic                   low_ones;
    logic                   low_zeros;

    assign d_s          = sync_q[SYNC_STAGES-1];
    assign rise         = d_s & ~d_prev_q;
    assign step         = rise & en & ~load;
    assign load_clamped = WIDTH'(clamp_mod(32'(load_val), 32'(MODULUS)));

    // Input path next-state: shift d through the synchronizer, track history.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], d};
        d_prev_d    = d_s;
        edge_seen_d = rise;
    end

    // Toggle enables from the low-order bits, overridden by load or wrap.
    always_comb begin
        t_vec       = '0;
        cell_ld     = 1'b0;
        cell_ld_val = '0;
        tc_d        = 1'b0;
        low_ones    = 1'b1;
        low_zeros   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_vec[i]  = step & (up ? low_ones : low_zeros);
            low_ones  = low_ones & q_cnt[i];
            low_zeros = low_zeros & ~q_cnt[i];
        end
        if (load) begin
            cell_ld     = 1'b1;
            cell_ld_val = load_clamped;
        end else if (step && up && (q_cnt == MAX_Q)) begin
            cell_ld     = 1'b1;
            cell_ld_val = '0;
            tc_d        = 1'b1;
        end else if (step && !up && (q_cnt == '0)) begin
            cell_ld     = 1'b1;
            cell_ld_val = MAX_Q;
            tc_d        = 1'b1;
        end
    end

    // Synchronizer, edge history and output pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            d_prev_q    <= 1'b0;
            edge_seen_q <= 1'b0;
            tc_q        <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            d_prev_q    <= d_prev_d;
            edge_seen_q <= edge_seen_d;
            tc_q        <= tc_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .t      (t_vec[i]),
            .ld     (cell_ld),
            .ld_val (cell_ld_val[i]),
            .q      (q_cnt[i])
        );
    end

    assign q         = q_cnt;
    assign tc        = tc_q;
    assign edge_seen = edge_seen_q;

endmodule

// File: tb/tb_t_edge_counter.sv
// Testbench for t_edge_counter: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_t_edge_counter;
    import flipflop_pkg::*;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk;
    logic             rst;
    logic             d;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             edge_seen;

    int n_checks = 0;
    int n_pass   = 0;

    t_edge_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .q         (q),
        .tc        (tc),
        .edge_seen (edge_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. An event is accepted on the clock edge two edges after
    // d was first sampled high (i.e. the third sampling edge); the count then
    // moves by +/-1 modulo MODULUS, a load replaces it with the clamped value.
    logic             s1, s2, s3;
    logic [WIDTH-1:0] m_q;
    logic             m_tc;
    logic             m_es;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            m_q <= '0; m_tc <= 1'b0; m_es <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            m_es <= s2 & ~s3;
            m_tc <= 1'b0;
            if (load) begin
                m_q <= WIDTH'(clamp_mod(32'(load_val), 32'(MODULUS)));
            end else if (s2 && !s3 && en) begin
                if (up) begin
                    m_q  <= WIDTH'((int'(m_q) + 1) % MODULUS);
                    m_tc <= (int'(m_q) == MODULUS - 1);
                end else begin
                    m_q  <= WIDTH'((int'(m_q) + MODULUS - 1) % MODULUS);
                    m_tc <= (m_q == '0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = WIDTH'(v);
        tick(1);
        load     = 1'b0;
    endtask

    // One clean pulse on d: 4 clocks high, 4 low. Counts output pulses seen.
    task automatic pulse(output int es_cnt, output int tc_cnt);
        es_cnt = 0;
        tc_cnt = 0;
        d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            es_cnt += int'(edge_seen);
            tc_cnt += int'(tc);
        end
        d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            es_cnt += int'(edge_seen);
            tc_cnt += int'(tc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; d = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
        tick(2);
        n_checks++;
        if (q !== '0) $display("FAIL reset_q: got %0d expected 0", q); else n_pass++;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL reset_tc: got %b expected 0", tc); else n_pass++;
        n_checks++;
        if (edge_seen !== 1'b0) $display("FAIL reset_edge_seen: got %b expected 0", edge_seen); else n_pass++;
        rst = 1'b0;
        tick(1);
        d = 1'b1;
        tick(2);
        n_checks++;
        if (edge_seen !== 1'b0 || q !== '0)
            $display("FAIL latency_early: edge_seen=%b q=%0d expected 0 and 0", edge_seen, q);
        else n_pass++;
        tick(1);
        n_checks++;
        if (edge_seen !== 1'b1) $display("FAIL latency_edge_seen: got %b expected 1", edge_seen); else n_pass++;
        n_checks++;
        if (q !== WIDTH'(1)) $display("FAIL latency_q: got %0d expected 1", q); else n_pass++;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL latency_tc: got %b expected 0", tc); else n_pass++;
        d = 1'b0;
        tick(4);
    endtask

    task automatic test_up_wrap;
        int es_c, tc_c;
        up = 1'b1;
        do_load(0);
        for (int i = 1; i <= 10; i++) begin
            pulse(es_c, tc_c);
            n_checks++;
            if (q !== WIDTH'(i % 10)) $display("FAIL up_q_%0d: got %0d expected %0d", i, q, i % 10); else n_pass++;
            n_checks++;
            if (tc_c !== ((i == 10) ? 1 : 0))
                $display("FAIL up_tc_%0d: got %0d pulses expected %0d", i, tc_c, (i == 10) ? 1 : 0);
            else n_pass++;
            n_checks++;
            if (es_c !== 1) $display("FAIL up_es_%0d: got %0d pulses expected 1", i, es_c); else n_pass++;
        end
    endtask

    task automatic test_down_wrap;
        int es_c, tc_c;
        int exp_q[3]  = '{1, 0, 9};
        int exp_tc[3] = '{0, 0, 1};
        do_load(2);
        up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(es_c, tc_c);
            n_checks++;
            if (q !== WIDTH'(exp_q[i])) $display("FAIL down_q_%0d: got %0d expected %0d", i, q, exp_q[i]); else n_pass++;
            n_checks++;
            if (tc_c !== exp_tc[i]) $display("FAIL down_tc_%0d: got %0d pulses expected %0d", i, tc_c, exp_tc[i]); else n_pass++;
        end
        up = 1'b1;
    endtask

    task automatic test_load_clamp;
        do_load(3);
        d = 1'b1;
        tick(2);
        load     = 1'b1;
        load_val = 4'hF;
        tick(1);
        n_checks++;
        if (q !== WIDTH'(9)) $display("FAIL clamp_q: got %0d expected 9", q); else n_pass++;
        n_checks++;
        if (edge_seen !== 1'b1) $display("FAIL clamp_edge_seen: got %b expected 1", edge_seen); else n_pass++;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL clamp_tc: got %b expected 0", tc); else n_pass++;
        load = 1'b0;
        tick(1);
        n_checks++;
        if (q !== WIDTH'(9)) $display("FAIL clamp_hold_q: got %0d expected 9", q); else n_pass++;
        d = 1'b0;
        tick(4);
    endtask

    task automatic test_enable;
        int es_c, tc_c, es_win;
        do_load(5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(es_c, tc_c);
            n_checks++;
            if (es_c !== 1 || q !== WIDTH'(5))
                $display("FAIL en_off_%0d: edge_seen pulses=%0d q=%0d expected 1 and 5", i, es_c, q);
            else n_pass++;
        end
        d = 1'b1;
        tick(5);
        en = 1'b1;
        es_win = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            es_win += int'(edge_seen);
        end
        n_checks++;
        if (q !== WIDTH'(5) || es_win !== 0)
            $display("FAIL en_resume_spurious: q=%0d edge_seen pulses=%0d expected 5 and 0", q, es_win);
        else n_pass++;
        d = 1'b0;
        tick(4);
        pulse(es_c, tc_c);
        n_checks++;
        if (q !== WIDTH'(6)) $display("FAIL en_resume_count: got %0d expected 6", q); else n_pass++;
    endtask

    task automatic test_async_reset;
        do_load(7);
        n_checks++;
        if (q !== WIDTH'(7)) $display("FAIL areset_pre_q: got %0d expected 7", q); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (q !== '0) $display("FAIL areset_q: got %0d expected 0", q); else n_pass++;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL areset_tc: got %b expected 0", tc); else n_pass++;
        #3;
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (q !== '0) $display("FAIL areset_after_q: got %0d expected 0", q); else n_pass++;
    endtask

    task automatic test_random;
        int bad_q, bad_tc, bad_es, bad_rng;
        bad_q = 0; bad_tc = 0; bad_es = 0; bad_rng = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2, 0) == 0) d = ~d;
            en       = ($urandom_range(9, 0) < 8);
            up       = $urandom_range(1, 0) == 1;
            load     = ($urandom_range(29, 0) == 0);
            load_val = WIDTH'($urandom_range(15, 0));
            tick(1);
            n_checks++;
            if (q !== m_q) begin
                if (bad_q < 5) $display("FAIL rand_q cycle %0d: got %0d expected %0d", i, q, m_q);
                bad_q++;
            end else n_pass++;
            n_checks++;
            if (tc !== m_tc) begin
                if (bad_tc < 5) $display("FAIL rand_tc cycle %0d: got %b expected %b", i, tc, m_tc);
                bad_tc++;
            end else n_pass++;
            n_checks++;
            if (edge_seen !== m_es) begin
                if (bad_es < 5) $display("FAIL rand_edge_seen cycle %0d: got %b expected %b", i, edge_seen, m_es);
                bad_es++;
            end else n_pass++;
            n_checks++;
            if (!(int'(q) < MODULUS)) begin
                if (bad_rng < 5) $display("FAIL rand_range cycle %0d: got %0d expected below %0d", i, q, MODULUS);
                bad_rng++;
            end else n_pass++;
        end
        load = 1'b0;
        d    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_enable();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
